serial_frame_rx: RTL

Serial-to-parallel frame receiver that sits directly upstream of the parallel-in/parallel-out register. It samples a serial bit stream under a bit-valid strobe, detects a start bit, and assembles WIDTH data bits LSB first. It checks the stop bit and emits the assembled word on a parallel bus together with a one-cycle load strobe. Its outputs connect straight to the downstream register's parallel input and load controls.

---
 rtl/serial_frame_rx.sv | 127 ++++++++++++
 1 files changed

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: serial-to-parallel frame receiver.
// Samples `si` on edges where `si_valid` is high. A frame is a start bit (0),
// WIDTH data bits LSB first, an optional even-parity bit and a stop bit (1).
// A good frame is copied to `po` with a one-cycle `load` pulse, and a rejected
// frame gives a one-cycle `frame_err` pulse.
// Optional feature: define PARITY_EN to expect an even-parity bit after the
// last data bit.
module serial_frame_rx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             si,
    input  logic             si_valid,
    output logic [WIDTH-1:0] po,
    output logic             load,
    output logic             frame_err,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] bit_cnt_r;
    logic [WIDTH-1:0] shift_r;
    logic             stop_ok_s;

`ifdef PARITY_EN
    logic par_err_r;

    // Even parity of a data word: 1 when the word holds an odd number of ones.
    function automatic logic even_par(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    // A frame is accepted only when the stop bit is 1 and the parity matched.
    always_comb begin
        stop_ok_s = si & ~par_err_r;
    end
`else
    // A frame is accepted only when the stop bit is 1.
    always_comb begin
        stop_ok_s = si;
    end
`endif

    // Receive FSM: all state, the output word and the strobes are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            bit_cnt_r <= '0;
            shift_r   <= '0;
            po        <= '0;
            load      <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
`ifdef PARITY_EN
            par_err_r <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle; they are re-asserted only on the stop edge.
            load      <= 1'b0;
            frame_err <= 1'b0;
            if (si_valid) begin
                case (state_r)
                    IDLE: begin
                        if (si == 1'b0) begin
                            state_r   <= DATA;
                            bit_cnt_r <= '0;
                            busy      <= 1'b1;
                        end else begin
                            state_r   <= IDLE;
                        end
                    end
                    DATA: begin
                        shift_r[bit_cnt_r] <= si;
                        if (bit_cnt_r == CNT_LAST) begin
                            bit_cnt_r <= '0;
`ifdef PARITY_EN
                            state_r   <= PARITY;
`else
                            state_r   <= STOP;
`endif
                        end else begin
                            bit_cnt_r <= bit_cnt_r + CNT_ONE;
                        end
                    end
`ifdef PARITY_EN
                    PARITY: begin
                        // Data XOR parity must be 0; remember a mismatch for STOP.
                        par_err_r <= even_par(shift_r) ^ si;
                        state_r   <= STOP;
                    end
`endif
                    STOP: begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                        if (stop_ok_s) begin
                            po   <= shift_r;
                            load <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: begin
                        // Unreachable encodings fall back to a clean idle.
                        state_r   <= IDLE;
                        bit_cnt_r <= '0;
                        busy      <= 1'b0;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule
